face_detect_mul_arbiter: RTL

- Shares one pipelined 16-bit-unsigned x 7-bit-signed -> 23-bit-signed multiplier (3 ce-enabled register stages, no reset) between NUM_REQ requesters inside the face-detection accelerator.
- Round-robin issues at most one operand pair per cycle and drives the multiplier clock enable.
- Tracks the requester ID through the pipeline and returns each product to its owner; the whole pipeline stalls on response backpressure.

---
 rtl/face_detect_mul_pkg.sv | 11 +
 rtl/face_detect_rr_arb.sv | 38 +++
 rtl/face_detect_mul_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/face_detect_mul_pkg.sv
// face_detect_mul_pkg: shared widths and helpers for the multiplier arbiter
package face_detect_mul_pkg;
    localparam int A_W_DEF = 16;
    localparam int B_W_DEF = 7;
    localparam int P_W_DEF = 23;
    localparam int PERF_W  = 32;

    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/face_detect_rr_arb.sv
// face_detect_rr_arb: combinational round-robin picker starting the search at ptr
module face_detect_rr_arb
    import face_detect_mul_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = tag_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic          hi_any;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // lowest requester at or above ptr wins; otherwise wrap to the lowest overall
    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        any    = 1'b0;
        grant  = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_idx = IW'(j);
                any    = 1'b1;
                if (IW'(j) >= ptr) begin
                    hi_idx = IW'(j);
                    hi_any = 1'b1;
                end
            end
        end
        idx = hi_any ? hi_idx : lo_idx;
        for (int j = 0; j < N; j++) grant[j] = any && (idx == IW'(j));
    end
endmodule

// File: rtl/face_detect_mul_arbiter.sv
// face_detect_mul_arbiter: round-robin sharing of one pipelined multiplier; FACE_DETECT_MUL_ARB_PERF_EN adds perf counters
module face_detect_mul_arbiter
    import face_detect_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 3,
    parameter int A_W     = A_W_DEF,
    parameter int B_W     = B_W_DEF,
    parameter int P_W     = P_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [P_W-1:0]         rsp_p,
    output logic                   mul_ce,
    output logic [A_W-1:0]         mul_din0,
    output logic [B_W-1:0]         mul_din1,
    input  logic [P_W-1:0]         mul_dout
`ifdef FACE_DETECT_MUL_ARB_PERF_EN
    ,
    output logic [NUM_REQ*PERF_W-1:0] perf_grant_cnt,
    output logic [PERF_W-1:0]         perf_stall_cnt
`endif
);
    localparam int TW = tag_w(NUM_REQ);

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [TW-1:0]      tag_q [LATENCY];
    logic [TW-1:0]      tag_d [LATENCY];
    logic [TW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] out_hit;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [TW-1:0]      g;
    logic               any;
    logic               stall;

    face_detect_rr_arb #(.N(NUM_REQ), .IW(TW)) u_arb (
        .req   (arb_req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (g),
        .any   (any)
    );

    assign rsp_p = mul_dout;

    // output-stage decode, stall, clock enable and granted operand mux
    always_comb begin
        out_hit = '0;
        for (int i = 0; i < NUM_REQ; i++) out_hit[i] = vld_q[LATENCY-1] && (tag_q[LATENCY-1] == TW'(i));
        stall     = |(out_hit & ~rsp_ready);
        mul_ce    = reset_n && !stall;
        arb_req   = mul_ce ? req_valid : '0;
        req_ready = grant;
        rsp_valid = reset_n ? out_hit : '0;
        mul_din0  = '0;
        mul_din1  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mul_din0 = req_a[i*A_W +: A_W];
                mul_din1 = req_b[i*B_W +: B_W];
            end
        end
    end

    // valid/tag shift only on mul_ce so tags stay aligned with the multiplier stages
    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        ptr_d = ptr_q;
        if (mul_ce) begin
            vld_d[0] = any;
            tag_d[0] = g;
            for (int k = 1; k < LATENCY; k++) begin
                vld_d[k] = vld_q[k-1];
                tag_d[k] = tag_q[k-1];
            end
            if (any) ptr_d = (g == TW'(NUM_REQ - 1)) ? '0 : g + TW'(1);
        end
    end

    // pipeline bookkeeping and round-robin pointer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            ptr_q <= '0;
            for (int k = 0; k < LATENCY; k++) tag_q[k] <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
            ptr_q <= ptr_d;
        end
    end

`ifdef FACE_DETECT_MUL_ARB_PERF_EN
    logic [PERF_W-1:0] grant_cnt_q [NUM_REQ];
    logic [PERF_W-1:0] grant_cnt_d [NUM_REQ];
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    // saturating per-requester grant counters and stall-cycle counter
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_d[i] = (grant[i] && !(&grant_cnt_q[i])) ? grant_cnt_q[i] + PERF_W'(1) : grant_cnt_q[i];
            perf_grant_cnt[i*PERF_W +: PERF_W] = grant_cnt_q[i];
        end
        stall_cnt_d    = (stall && !(&stall_cnt_q)) ? stall_cnt_q + PERF_W'(1) : stall_cnt_q;
        perf_stall_cnt = stall_cnt_q;
    end

    // perf counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
        end
    end
`endif
endmodule
